// File: rtl/pc_trace_monitor_if.sv
// ---------------------------------------------------------------------------
// pc_trace_monitor_if
//   Bundles the signals between the CPU-side observer (master) and the
//   pc_trace_monitor (slave).
//
//   master drives : pc, pc_load, halt, clr, timeout_limit, rd_idx
//   slave  drives : rd_pc, state, done, done_pulse, cycle_count,
//                   instr_count, trace_count
// ---------------------------------------------------------------------------
interface pc_trace_monitor_if #(
    parameter int PC_W  = 9,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [PC_W-1:0]  pc;
    logic             pc_load;
    logic             halt;
    logic             clr;
    logic [CNT_W-1:0] timeout_limit;
    logic [IDX_W-1:0] rd_idx;

    logic [PC_W-1:0]  rd_pc;
    logic [2:0]       state;
    logic             done;
    logic             done_pulse;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;
    logic [IDX_W:0]   trace_count;

    modport master (
        output pc, pc_load, halt, clr, timeout_limit, rd_idx,
        input  rd_pc, state, done, done_pulse, cycle_count, instr_count,
               trace_count
    );

    modport slave (
        input  pc, pc_load, halt, clr, timeout_limit, rd_idx,
        output rd_pc, state, done, done_pulse, cycle_count, instr_count,
               trace_count
    );
endinterface

// File: rtl/pc_trace_monitor.sv
// ---------------------------------------------------------------------------
// pc_trace_monitor
//   Run monitor for the simple RISC CPU. Checks that the first fetch after
//   reset/clear is from address 0, counts cycles and fetches, enforces an
//   optional cycle timeout before HALT, and keeps a circular history of the
//   last DEPTH fetched PCs for readback.
//
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   mon    : pc_trace_monitor_if.slave
//            in : pc, pc_load, halt, clr, timeout_limit, rd_idx
//            out: rd_pc (registered trace readback, 0 = newest),
//                 state (0 IDLE, 1 RUN, 2 HALTED, 3 TIMEOUT, 4 BADSTART),
//                 done, done_pulse, cycle_count, instr_count, trace_count
// ---------------------------------------------------------------------------
module pc_trace_monitor #(
    parameter int PC_W  = 9,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    pc_trace_monitor_if.slave mon
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = AW + 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [TW-1:0]    TRACE_FULL = TW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        HALTED   = 3'd2,
        TIMEOUT  = 3'd3,
        BADSTART = 3'd4
    } state_t;

    state_t           st_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;
    logic [TW-1:0]    trace_cnt_q;
    logic [AW-1:0]    wr_ptr_q;
    logic [PC_W-1:0]  rd_pc_q;
    logic             done_q;
    logic             done_pulse_q;
    logic [PC_W-1:0]  trace_mem [DEPTH];

    logic             active;
    logic             fetch;
    logic             tmo_hit;
    logic [CNT_W:0]   cycle_inc;
    logic [AW-1:0]    rd_addr;
    logic             rd_valid;

    assign active    = (st_q == IDLE) || (st_q == RUN);
    // A fetch is recorded only while the run is live and not being cleared.
    assign fetch     = active && mon.pc_load && !mon.clr;
    // One extra bit so a saturated counter can never alias onto the limit.
    assign cycle_inc = {1'b0, cycle_q} + (CNT_W+1)'(1);
    assign tmo_hit   = (mon.timeout_limit != '0) &&
                       (cycle_inc == {1'b0, mon.timeout_limit});
    // Newest entry sits just behind the write pointer; DEPTH is a power of
    // two so the subtraction wraps naturally.
    assign rd_addr   = wr_ptr_q - AW'(1) - mon.rd_idx;
    assign rd_valid  = {1'b0, mon.rd_idx} < trace_cnt_q;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q         <= IDLE;
            cycle_q      <= '0;
            instr_q      <= '0;
            trace_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else if (mon.clr) begin
            st_q         <= IDLE;
            cycle_q      <= '0;
            instr_q      <= '0;
            trace_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;

            // On a timeout cycle the increment lands exactly on the limit.
            if (active && (cycle_q != CNT_MAX)) begin
                cycle_q <= cycle_inc[CNT_W-1:0];
            end

            case (st_q)
                IDLE: begin
                    // The start check outranks a timeout on the same cycle.
                    if (mon.pc_load) begin
                        if (mon.pc == '0) begin
                            st_q <= RUN;
                        end else begin
                            st_q         <= BADSTART;
                            done_q       <= 1'b1;
                            done_pulse_q <= 1'b1;
                        end
                    end else if (tmo_hit) begin
                        st_q         <= TIMEOUT;
                        done_q       <= 1'b1;
                        done_pulse_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (mon.halt) begin
                        st_q         <= HALTED;
                        done_q       <= 1'b1;
                        done_pulse_q <= 1'b1;
                    end else if (tmo_hit) begin
                        st_q         <= TIMEOUT;
                        done_q       <= 1'b1;
                        done_pulse_q <= 1'b1;
                    end
                end
                default: begin
                    // Terminal states hold until reset or clr.
                end
            endcase

            if (fetch) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
                if (instr_q != CNT_MAX) begin
                    instr_q <= instr_q + CNT_W'(1);
                end
                if (trace_cnt_q != TRACE_FULL) begin
                    trace_cnt_q <= trace_cnt_q + TW'(1);
                end
            end
        end
    end

    // NOTE: the trace RAM has no reset so it maps onto plain memory; entries
    // at or beyond trace_count are never returned, so stale contents are
    // harmless.
    always_ff @(posedge clk) begin
        if (fetch) begin
            trace_mem[wr_ptr_q] <= mon.pc;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_pc_q <= '0;
        end else if (mon.clr) begin
            rd_pc_q <= '0;
        end else begin
            rd_pc_q <= rd_valid ? trace_mem[rd_addr] : '0;
        end
    end

    assign mon.state       = st_q;
    assign mon.done        = done_q;
    assign mon.done_pulse  = done_pulse_q;
    assign mon.cycle_count = cycle_q;
    assign mon.instr_count = instr_q;
    assign mon.trace_count = trace_cnt_q;
    assign mon.rd_pc       = rd_pc_q;
endmodule
